fpga_lcd_ctrl: RTL and testbench

- FPGA-side driver for the 16x2 HD44780-style text LCD.
- Produces the F_LCD_RS/F_LCD_RW/F_LCD_E/F_LCD_D bus that the host/FPGA output selector forwards to the LCD pins whenever V_SEL=0.
- Holds a 32-character display buffer that user logic writes at any time.
- Runs the LCD power-up/init sequence, then refreshes both lines from the buffer continuously.

---
 rtl/fpga_lcd_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_fpga_lcd_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_lcd_ctrl.sv
// fpga_lcd_ctrl: FPGA-side driver for a 16x2 HD44780-style character LCD.
// Keeps a 32-entry character buffer that user logic can write at any time.
// After reset it waits out LCD power-up, sends the init commands and then
// continuously refreshes both display lines from the buffer. The LCD is
// write-only: timing is met with cycle counters, and the busy flag is never read.

module fpga_lcd_ctrl #(
  parameter int E_CYC      = 50,       // cycles per bus phase (SETUP/PULSE/HOLD), >= 1
  parameter int PWRUP_WAIT = 2000000,  // idle cycles after reset before the first command
  parameter int CLR_WAIT   = 100000    // extra idle cycles after the clear-display command
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       WR_EN,
  input  logic [4:0] WR_ADDR,
  input  logic [7:0] WR_DATA,
  output logic       F_LCD_RS,
  output logic       F_LCD_RW,
  output logic       F_LCD_E,
  output logic [7:0] F_LCD_D,
  output logic       INIT_DONE,
  output logic       FRAME_PULSE
);

  // Wait counter must hold the longer of the two idle periods without wrapping.
  localparam int WAIT_MAX = (PWRUP_WAIT > CLR_WAIT) ? PWRUP_WAIT : CLR_WAIT;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int PH_W     = (E_CYC > 1) ? $clog2(E_CYC) : 1;

  // Transaction index: 0..3 during INIT, 0..33 during FRAME.
  localparam logic [5:0] IDX_INIT_LAST  = 6'd3;
  localparam logic [5:0] IDX_FRAME_LAST = 6'd33;
  localparam logic [5:0] IDX_LINE2_CMD  = 6'd17;

  localparam logic [7:0] CMD_LINE1 = 8'h80;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    S_PWRUP   = 2'd0,
    S_INIT    = 2'd1,
    S_CLRWAIT = 2'd2,
    S_FRAME   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    P_SETUP = 2'd0,
    P_PULSE = 2'd1,
    P_HOLD  = 2'd2
  } phase_t;

  state_t            r_state;
  state_t            w_state_nxt;
  phase_t            r_phase;
  logic [PH_W-1:0]   r_phase_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [5:0]        r_idx;
  logic              r_lcd_rs;
  logic [7:0]        r_lcd_d;
  logic              r_init_done;
  logic              r_frame_pulse;
  logic [7:0]        r_buf [32];

  logic              w_bus_active;
  logic              w_phase_last;
  logic              w_txn_last;
  logic              w_init_last;
  logic              w_frame_last;
  logic [WAIT_W-1:0] w_wait_tgt;
  logic              w_wait_last;
  logic              w_start_txn;
  logic [5:0]        w_nxt_idx;
  logic              w_nxt_rs;
  logic [7:0]        w_nxt_d;

  // ---------------------------------------------------------------------------
  // Character buffer
  // ---------------------------------------------------------------------------

  // Buffer write port; every strobe is accepted, later writes overwrite earlier ones.
  // NOTE: this memory is reset on purpose -- the display must show spaces after reset,
  // so the buffer lives in flops rather than a RAM that cannot be cleared in one cycle.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < 32; i++) begin
        r_buf[i] <= CHAR_SPACE;
      end
    end else if (WR_EN) begin
      r_buf[WR_ADDR] <= WR_DATA;
    end
  end

  // ---------------------------------------------------------------------------
  // Timing decode
  // ---------------------------------------------------------------------------

  // Decode end-of-phase, end-of-transaction and end-of-wait conditions.
  always_comb begin
    w_bus_active = (r_state == S_INIT) || (r_state == S_FRAME);
    w_phase_last = (r_phase_cnt == PH_W'(E_CYC - 1));
    w_txn_last   = w_bus_active && (r_phase == P_HOLD) && w_phase_last;
    w_init_last  = (r_state == S_INIT)  && (r_idx == IDX_INIT_LAST)  && w_txn_last;
    w_frame_last = (r_state == S_FRAME) && (r_idx == IDX_FRAME_LAST) && w_txn_last;
    w_wait_tgt   = (r_state == S_PWRUP) ? WAIT_W'(PWRUP_WAIT - 1) : WAIT_W'(CLR_WAIT - 1);
    w_wait_last  = (r_wait_cnt == w_wait_tgt);
    // A new SETUP begins when a wait expires or a transaction ends with more to send.
    // The last INIT command hands over to CLRWAIT instead.
    w_start_txn  = ((r_state == S_PWRUP)   && w_wait_last) ||
                   ((r_state == S_CLRWAIT) && w_wait_last) ||
                   ((r_state == S_INIT)    && w_txn_last && !w_init_last) ||
                   ((r_state == S_FRAME)   && w_txn_last);
  end

  // Select the index and bus contents of the transaction about to start.
  // NOTE: every signal driven here gets a default first so no path can leave it
  // unassigned; a missing default on an always_comb output infers a latch.
  always_comb begin
    w_nxt_idx = 6'd0;
    w_nxt_rs  = 1'b0;
    w_nxt_d   = 8'h00;
    case (r_state)
      S_INIT:  w_nxt_idx = 6'(r_idx + 6'd1);
      S_FRAME: w_nxt_idx = (r_idx == IDX_FRAME_LAST) ? 6'd0 : 6'(r_idx + 6'd1);
      default: w_nxt_idx = 6'd0;
    endcase
    if ((r_state == S_PWRUP) || (r_state == S_INIT)) begin
      // Function set 8-bit/2-line, display on, entry mode increment, clear.
      case (w_nxt_idx[1:0])
        2'd0:    w_nxt_d = 8'h38;
        2'd1:    w_nxt_d = 8'h0C;
        2'd2:    w_nxt_d = 8'h06;
        default: w_nxt_d = 8'h01;
      endcase
    end else if (w_nxt_idx == 6'd0) begin
      w_nxt_d = CMD_LINE1;
    end else if (w_nxt_idx == IDX_LINE2_CMD) begin
      w_nxt_d = CMD_LINE2;
    end else if (w_nxt_idx < IDX_LINE2_CMD) begin
      w_nxt_rs = 1'b1;
      w_nxt_d  = r_buf[5'(w_nxt_idx - 6'd1)];
    end else begin
      w_nxt_rs = 1'b1;
      w_nxt_d  = r_buf[5'(w_nxt_idx - 6'd2)];
    end
  end

  // ---------------------------------------------------------------------------
  // Main FSM
  // ---------------------------------------------------------------------------

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= S_PWRUP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: PWRUP -> INIT -> CLRWAIT -> FRAME, FRAME repeats forever.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_PWRUP:   if (w_wait_last) w_state_nxt = S_INIT;
      S_INIT:    if (w_init_last) w_state_nxt = S_CLRWAIT;
      S_CLRWAIT: if (w_wait_last) w_state_nxt = S_FRAME;
      default:   w_state_nxt = S_FRAME;
    endcase
  end

  // Output decode: E is high only in PULSE; RS/D come from the latched bus registers.
  always_comb begin
    F_LCD_E     = w_bus_active && (r_phase == P_PULSE);
    F_LCD_RS    = r_lcd_rs;
    F_LCD_D     = r_lcd_d;
    F_LCD_RW    = 1'b0;
    INIT_DONE   = r_init_done;
    FRAME_PULSE = r_frame_pulse;
  end

  // ---------------------------------------------------------------------------
  // Counters and bus registers
  // ---------------------------------------------------------------------------

  // Idle counter for the power-up and post-clear waits; cleared outside them.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_wait_cnt <= '0;
    end else if (((r_state == S_PWRUP) || (r_state == S_CLRWAIT)) && !w_wait_last) begin
      r_wait_cnt <= WAIT_W'(r_wait_cnt + 1'b1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Phase sequencer: SETUP -> PULSE -> HOLD, E_CYC cycles each.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_phase     <= P_SETUP;
      r_phase_cnt <= '0;
    end else if (w_start_txn || !w_bus_active) begin
      r_phase     <= P_SETUP;
      r_phase_cnt <= '0;
    end else if (w_phase_last) begin
      r_phase_cnt <= '0;
      case (r_phase)
        P_SETUP: r_phase <= P_PULSE;
        P_PULSE: r_phase <= P_HOLD;
        default: r_phase <= P_SETUP;
      endcase
    end else begin
      r_phase_cnt <= PH_W'(r_phase_cnt + 1'b1);
    end
  end

  // Latch index, RS and D at SETUP entry; they stay put until the next SETUP,
  // so buffer writes during a transaction only show up in the following frame.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_idx    <= 6'd0;
      r_lcd_rs <= 1'b0;
      r_lcd_d  <= 8'h00;
    end else if (w_start_txn) begin
      r_idx    <= w_nxt_idx;
      r_lcd_rs <= w_nxt_rs;
      r_lcd_d  <= w_nxt_d;
    end
  end

  // Status flags: INIT_DONE is sticky until reset, FRAME_PULSE marks each frame end.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_init_done   <= 1'b0;
      r_frame_pulse <= 1'b0;
    end else begin
      if ((r_state == S_CLRWAIT) && w_wait_last) begin
        r_init_done <= 1'b1;
      end
      r_frame_pulse <= w_frame_last;
    end
  end

endmodule

// File: tb/tb_fpga_lcd_ctrl.sv
// tb_fpga_lcd_ctrl: self-checking bench for fpga_lcd_ctrl with small timing
// parameters. A transaction-level model derives the expected bus activity from
// the documented schedule (fixed wait lengths, 12-cycle transactions, 34
// transactions per frame) and a mirror of the character buffer.

module tb_fpga_lcd_ctrl;

  localparam int E_CYC      = 4;
  localparam int PWRUP_WAIT = 100;
  localparam int CLR_WAIT   = 20;
  localparam int T          = 3 * E_CYC;               // one transaction
  localparam int INIT_END   = PWRUP_WAIT + 4 * T;      // first CLRWAIT cycle
  localparam int FRM0       = INIT_END + CLR_WAIT;     // first frame SETUP cycle
  localparam int FRM_LEN    = 34 * T;
  localparam int MAXP       = 256;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       WR_EN;
  logic [4:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic       F_LCD_RS;
  logic       F_LCD_RW;
  logic       F_LCD_E;
  logic [7:0] F_LCD_D;
  logic       INIT_DONE;
  logic       FRAME_PULSE;

  fpga_lcd_ctrl #(
    .E_CYC      (E_CYC),
    .PWRUP_WAIT (PWRUP_WAIT),
    .CLR_WAIT   (CLR_WAIT)
  ) dut (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .WR_EN       (WR_EN),
    .WR_ADDR     (WR_ADDR),
    .WR_DATA     (WR_DATA),
    .F_LCD_RS    (F_LCD_RS),
    .F_LCD_RW    (F_LCD_RW),
    .F_LCD_E     (F_LCD_E),
    .F_LCD_D     (F_LCD_D),
    .INIT_DONE   (INIT_DONE),
    .FRAME_PULSE (FRAME_PULSE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         s;   // cycle the SETUP begins
    int         n;   // pulse number since reset release
    logic       rs;
    logic [7:0] d;
  } txn_t;

  txn_t       q[$];
  logic [7:0] mdl_buf [32];
  logic [7:0] cap_d   [MAXP];
  logic       cap_rs  [MAXP];
  int         cyc;
  int         run;
  int         rnd_lo, rnd_hi;
  int         first_rise, init_rise, first_fp;
  logic       prev_e;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", tag, cyc, act, exp);
    end
  endtask

  // E is high during the middle third of each transaction slot.
  function automatic bit exp_e(input int c);
    int off;
    if (c >= PWRUP_WAIT && c < INIT_END) begin
      off = (c - PWRUP_WAIT) % T;
      return (off >= E_CYC) && (off < 2 * E_CYC);
    end
    if (c >= FRM0) begin
      off = (c - FRM0) % T;
      return (off >= E_CYC) && (off < 2 * E_CYC);
    end
    return 1'b0;
  endfunction

  // Pulse number whose SETUP starts at cycle c, or -1.
  function automatic int pulse_at(input int c);
    if (c >= PWRUP_WAIT && c < INIT_END && ((c - PWRUP_WAIT) % T) == 0) return (c - PWRUP_WAIT) / T;
    if (c >= FRM0 && ((c - FRM0) % T) == 0) return 4 + (c - FRM0) / T;
    return -1;
  endfunction

  // What pulse n should carry, given the current buffer contents.
  function automatic txn_t exp_txn(input int n, input int s);
    txn_t t;
    int   k;
    t.s = s;
    t.n = n;
    t.rs = 1'b0;
    t.d = 8'h00;
    if (n < 4) begin
      case (n)
        0:       t.d = 8'h38;
        1:       t.d = 8'h0C;
        2:       t.d = 8'h06;
        default: t.d = 8'h01;
      endcase
    end else begin
      k = (n - 4) % 34;
      if (k == 0)       t.d = 8'h80;
      else if (k == 17) t.d = 8'hC0;
      else if (k < 17)  begin t.rs = 1'b1; t.d = mdl_buf[k - 1]; end
      else              begin t.rs = 1'b1; t.d = mdl_buf[k - 2]; end
    end
    return t;
  endfunction

  task automatic do_write(input int addr, input int data);
    WR_EN   = 1'b1;
    WR_ADDR = 5'(addr);
    WR_DATA = 8'(data);
  endtask

  task automatic drive_inputs();
    WR_EN   = 1'b0;
    WR_ADDR = 5'd0;
    WR_DATA = 8'h00;
    if (run == 0) begin
      case (cyc)
        10:  do_write(0, 8'h58);
        11:  do_write(0, 8'h48);   // same address next cycle: this one must win
        12:  do_write(31, 8'h21);
        244: begin                 // addr-5 character of frame 1 is in PULSE here
          check("e_at_addr5_write", 32'(F_LCD_E), 32'd1);
          do_write(5, 8'h41);
        end
        default: ;
      endcase
    end
    if (cyc >= rnd_lo && cyc < rnd_hi && $urandom_range(0, 3) == 0) begin
      do_write(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
    end
  endtask

  task automatic reset_model();
    cyc = 0;
    q.delete();
    for (int i = 0; i < 32; i++) mdl_buf[i] = 8'h20;
    for (int i = 0; i < MAXP; i++) begin
      cap_d[i]  = 8'h00;
      cap_rs[i] = 1'b0;
    end
    first_rise = -1;
    init_rise  = -1;
    first_fp   = -1;
    prev_e     = 1'b0;
  endtask

  // One clock cycle: update the model at the edge, then check at the falling edge.
  task automatic tick();
    int nxt;
    int n;
    @(posedge CLK);
    nxt = cyc + 1;
    n = pulse_at(nxt);
    // The DUT latches D from the buffer as it stood before this edge's write.
    if (n >= 0) q.push_back(exp_txn(n, nxt));
    if (WR_EN) mdl_buf[WR_ADDR] = WR_DATA;
    @(negedge CLK);
    cyc = nxt;
    check("rw", 32'(F_LCD_RW), 32'd0);
    check("e", 32'(F_LCD_E), 32'(exp_e(cyc)));
    check("init_done", 32'(INIT_DONE), 32'(cyc >= FRM0));
    check("frame_pulse", 32'(FRAME_PULSE), 32'(cyc >= FRM0 + FRM_LEN && ((cyc - FRM0) % FRM_LEN) == 0));
    if (cyc < PWRUP_WAIT) begin
      check("pwrup_rs", 32'(F_LCD_RS), 32'd0);
      check("pwrup_d", 32'(F_LCD_D), 32'd0);
    end
    if (q.size() > 0) begin
      check("bus_rs", 32'(F_LCD_RS), 32'(q[0].rs));
      check("bus_d", 32'(F_LCD_D), 32'(q[0].d));
      if (cyc == q[0].s + E_CYC && q[0].n < MAXP) begin
        cap_d[q[0].n]  = F_LCD_D;
        cap_rs[q[0].n] = F_LCD_RS;
      end
      if (cyc == q[0].s + T - 1) void'(q.pop_front());
    end
    if (F_LCD_E && !prev_e && first_rise < 0) first_rise = cyc;
    if (INIT_DONE && init_rise < 0) init_rise = cyc;
    if (FRAME_PULSE && first_fp < 0) first_fp = cyc;
    prev_e = F_LCD_E;
    drive_inputs();
  endtask

  // Checks common to the first frame after every reset release.
  task automatic check_startup();
    check("first_e_rise", 32'(first_rise), 32'd104);
    check("init_done_rise", 32'(init_rise), 32'd168);
    check("first_frame_pulse", 32'(first_fp), 32'd576);
    check("init_cmd0", 32'(cap_d[0]), 32'h38);
    check("init_cmd1", 32'(cap_d[1]), 32'h0C);
    check("init_cmd2", 32'(cap_d[2]), 32'h06);
    check("init_cmd3", 32'(cap_d[3]), 32'h01);
    for (int i = 0; i < 4; i++) check("init_rs", 32'(cap_rs[i]), 32'd0);
    check("f1_cmd80", 32'(cap_d[4]), 32'h80);
    check("f1_cmd80_rs", 32'(cap_rs[4]), 32'd0);
    check("f1_cmdC0", 32'(cap_d[21]), 32'hC0);
    check("f1_cmdC0_rs", 32'(cap_rs[21]), 32'd0);
  endtask

  initial begin
    RESETN  = 1'b0;
    WR_EN   = 1'b0;
    WR_ADDR = 5'd0;
    WR_DATA = 8'h00;
    run     = 0;
    rnd_lo  = 700;
    rnd_hi  = 1700;
    reset_model();
    repeat (3) @(negedge CLK);
    check("rst_e", 32'(F_LCD_E), 32'd0);
    check("rst_rs", 32'(F_LCD_RS), 32'd0);
    check("rst_rw", 32'(F_LCD_RW), 32'd0);
    check("rst_d", 32'(F_LCD_D), 32'd0);
    check("rst_init_done", 32'(INIT_DONE), 32'd0);
    check("rst_frame_pulse", 32'(FRAME_PULSE), 32'd0);
    RESETN = 1'b1;

    // Run 0: directed writes during PWRUP and mid-pulse, then random traffic.
    while (cyc < 1820) tick();
    check_startup();
    check("f1_first_data", 32'(cap_d[5]), 32'h48);
    check("f1_last_data", 32'(cap_d[37]), 32'h21);
    check("f1_addr5_kept", 32'(cap_d[10]), 32'h20);
    check("f2_addr5_new", 32'(cap_d[44]), 32'h41);
    for (int n = 5; n <= 37; n++) begin
      if (n != 21) check("f1_data_rs", 32'(cap_rs[n]), 32'd1);
    end

    // Reset for one cycle while E is high, mid-frame.
    for (int k = 0; k < 50 && !F_LCD_E; k++) tick();
    check("e_high_before_reset", 32'(F_LCD_E), 32'd1);
    WR_EN  = 1'b0;
    RESETN = 1'b0;
    #1;
    check("async_e_drop", 32'(F_LCD_E), 32'd0);
    check("async_init_done", 32'(INIT_DONE), 32'd0);
    check("async_d", 32'(F_LCD_D), 32'd0);
    check("async_rs", 32'(F_LCD_RS), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
    run    = 1;
    rnd_lo = 600;
    rnd_hi = 1000;
    reset_model();

    // Run 1: no writes during frame 1, so every character must be the reset space.
    while (cyc < 1300) tick();
    check_startup();
    for (int n = 5; n <= 37; n++) begin
      if (n != 21) check("buf_reset_data", 32'(cap_d[n]), 32'h20);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
